// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: writeback select encodings, MEM-stage FSM states
// and the default datapath width.
package riscv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads the MEM-stage instruction, or injects a bubble that
// clears the control fields while holding the data fields. Optional MEM_ALIGN_CHECK_EN adds misalign.
module mem_wb_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_bubble,
    input  logic              i_regwrite,
    input  logic [1:0]        i_wbsel,
    input  logic [XLEN-1:0]   i_alures,
    input  logic [XLEN-1:0]   i_readdata,
    input  logic [XLEN-1:0]   i_pc4,
    input  logic [REG_AW-1:0] i_rd,
`ifdef MEM_ALIGN_CHECK_EN
    input  logic              i_misalign,
    output logic              o_misalign,
`endif
    output logic              o_regwrite,
    output logic [1:0]        o_wbsel,
    output logic [XLEN-1:0]   o_alures,
    output logic [XLEN-1:0]   o_readdata,
    output logic [XLEN-1:0]   o_pc4,
    output logic [REG_AW-1:0] o_rd
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_regwrite <= 1'b0;
            o_wbsel    <= 2'b00;
            o_alures   <= '0;
            o_readdata <= '0;
            o_pc4      <= '0;
            o_rd       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            o_misalign <= 1'b0;
`endif
        end else if (i_bubble) begin
            // Data fields hold; only what could cause a register write is cleared.
            o_regwrite <= 1'b0;
            o_wbsel    <= 2'b00;
            o_rd       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            o_misalign <= 1'b0;
`endif
        end else begin
            o_regwrite <= i_regwrite;
            o_wbsel    <= i_wbsel;
            o_alures   <= i_alures;
            o_readdata <= i_readdata;
            o_pc4      <= i_pc4;
            o_rd       <= i_rd;
`ifdef MEM_ALIGN_CHECK_EN
            o_misalign <= i_misalign;
`endif
        end
    end

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM stage: drives the data-memory req/ack bus, stalls while an access is pending
// and owns the MEM/WB register. MEM_ALIGN_CHECK_EN enables misaligned-access trapping.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regwriteM,
    input  logic              memrwM,
    input  logic [1:0]        wbselM,
    input  logic [XLEN-1:0]   ALUresM,
    input  logic [XLEN-1:0]   data_writeM,
    input  logic [REG_AW-1:0] rdM,
    input  logic [XLEN-1:0]   pc4M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              stallM,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              misalignW,
`endif
    output logic              regwriteW,
    output logic [1:0]        wbselW,
    output logic [XLEN-1:0]   ALUresW,
    output logic [XLEN-1:0]   readdataW,
    output logic [XLEN-1:0]   pc4W,
    output logic [REG_AW-1:0] rdW
);

    logic       w_access;
    logic       w_misalign;
    logic       w_req;
    mem_state_t r_state;

    assign w_access = memrwM | (wbselM == WB_MEM);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_access & (ALUresM[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req = w_access & ~w_misalign;

    // Gating with rst_n makes the request drop the instant reset asserts, even mid-WAIT.
    assign dmem_req   = w_req & rst_n;
    assign stallM     = w_req & ~dmem_ack & rst_n;
    assign dmem_we    = memrwM;
    assign dmem_addr  = ALUresM;
    assign dmem_wdata = data_writeM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_req && !dmem_ack) r_state <= ST_WAIT;
                ST_WAIT: if (dmem_ack || !w_req) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mem_wb_reg #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_mem_wb_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_bubble   (stallM),
        .i_regwrite (regwriteM & ~w_misalign),
        .i_wbsel    (wbselM),
        .i_alures   (ALUresM),
        .i_readdata (dmem_rdata),
        .i_pc4      (pc4M),
        .i_rd       (rdM),
`ifdef MEM_ALIGN_CHECK_EN
        .i_misalign (w_misalign),
        .o_misalign (misalignW),
`endif
        .o_regwrite (regwriteW),
        .o_wbsel    (wbselW),
        .o_alures   (ALUresW),
        .o_readdata (readdataW),
        .o_pc4      (pc4W),
        .o_rd       (rdW)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by randomized traffic
// checked against a cycle-level behavioural model of the MEM stage rules.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        regwriteM, memrwM;
    logic [1:0]  wbselM;
    logic [31:0] ALUresM, data_writeM, pc4M, dmem_rdata;
    logic [4:0]  rdM;
    logic        dmem_req, dmem_we, dmem_ack, stallM;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        regwriteW;
    logic [1:0]  wbselW;
    logic [31:0] ALUresW, readdataW, pc4W;
    logic [4:0]  rdW;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalignW;
`endif

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .regwriteM(regwriteM), .memrwM(memrwM), .wbselM(wbselM),
        .ALUresM(ALUresM), .data_writeM(data_writeM), .rdM(rdM), .pc4M(pc4M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stallM(stallM),
`ifdef MEM_ALIGN_CHECK_EN
        .misalignW(misalignW),
`endif
        .regwriteW(regwriteW), .wbselW(wbselW), .ALUresW(ALUresW),
        .readdataW(readdataW), .pc4W(pc4W), .rdW(rdW)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Behavioural model of the MEM/WB contents
    logic        e_rw;
    logic [1:0]  e_wb;
    logic [31:0] e_alu, e_rdata, e_pc4;
    logic [4:0]  e_rd;
    logic        e_mis;
    logic        e_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        e_rw = 0; e_wb = 0; e_alu = 0; e_rdata = 0; e_pc4 = 0; e_rd = 0; e_mis = 0;
    endtask

    task automatic drive(input logic rw, input logic mrw, input logic [1:0] wb,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc4,
                         input logic ack, input logic [31:0] rdata);
        regwriteM = rw; memrwM = mrw; wbselM = wb; ALUresM = addr; data_writeM = wd;
        rdM = rd; pc4M = pc4; dmem_ack = ack; dmem_rdata = rdata;
    endtask

    // One clock: check bus outputs before the edge, advance the model, check W after it.
    task automatic step();
        logic acc, mis, req;
        #1;
        acc = memrwM || (wbselM == 2'b01);
`ifdef MEM_ALIGN_CHECK_EN
        mis = acc && (ALUresM[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        req = acc && !mis;
        e_stall = req && !dmem_ack;
        chk("dmem_req", {31'd0, dmem_req}, {31'd0, req});
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, memrwM});
        chk("dmem_addr", dmem_addr, ALUresM);
        chk("dmem_wdata", dmem_wdata, data_writeM);
        chk("stallM", {31'd0, stallM}, {31'd0, e_stall});
        @(posedge clk);
        if (e_stall) begin
            e_rw = 0; e_wb = 0; e_rd = 0; e_mis = 0;
        end else begin
            e_rw = regwriteM && !mis; e_wb = wbselM; e_alu = ALUresM;
            e_rdata = dmem_rdata; e_pc4 = pc4M; e_rd = rdM; e_mis = mis;
        end
        #1;
        chk("regwriteW", {31'd0, regwriteW}, {31'd0, e_rw});
        chk("wbselW", {30'd0, wbselW}, {30'd0, e_wb});
        chk("ALUresW", ALUresW, e_alu);
        chk("pc4W", pc4W, e_pc4);
        chk("rdW", {27'd0, rdW}, {27'd0, e_rd});
        if (e_wb == 2'b01) chk("readdataW", readdataW, e_rdata);
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalignW", {31'd0, misalignW}, {31'd0, e_mis});
`endif
    endtask

    task automatic chk_w_zero(input string tag);
        chk({tag, "_regwriteW"}, {31'd0, regwriteW}, 32'd0);
        chk({tag, "_wbselW"}, {30'd0, wbselW}, 32'd0);
        chk({tag, "_ALUresW"}, ALUresW, 32'd0);
        chk({tag, "_readdataW"}, readdataW, 32'd0);
        chk({tag, "_pc4W"}, pc4W, 32'd0);
        chk({tag, "_rdW"}, {27'd0, rdW}, 32'd0);
    endtask

    initial begin
        logic held;
        // Reset asserted while a load is presented with ack high
        rst_n = 1'b0;
        drive(1, 0, 2'b01, 32'h100, 32'h0, 5'd5, 32'h4, 1'b1, 32'hCAFEF00D);
        model_reset();
        #2;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stallM}, 32'd0);
        @(posedge clk); #1;
        chk_w_zero("rst");
        @(negedge clk);
        drive(0, 0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h0);
        rst_n = 1'b1;
        step();
        $display("txn: reset release, no spurious request");

        // Zero-wait load
        drive(1, 0, 2'b01, 32'h100, 32'h0, 5'd5, 32'h104, 1'b1, 32'hDEADBEEF);
        step();
        chk("zw_readdataW", readdataW, 32'hDEADBEEF);
        $display("txn: zero-wait load rd=%0d data=%h", rdW, readdataW);

        // Store with two wait cycles
        drive(0, 1, 2'b00, 32'h200, 32'h12345678, 5'd0, 32'h108, 1'b0, 32'h0);
        step(); chk("st_bubble1", {31'd0, regwriteW}, 32'd0);
        step(); chk("st_bubble2", {31'd0, regwriteW}, 32'd0);
        dmem_ack = 1'b1;
        step(); chk("st_done_alu", ALUresW, 32'h200);
        $display("txn: store with two wait cycles addr=%h", ALUresW);

        // ALU passthrough
        drive(1, 0, 2'b00, 32'h2A, 32'h0, 5'd7, 32'h10C, 1'b0, 32'h0);
        step();
        chk("alu_rdW", {27'd0, rdW}, 32'd7);
        $display("txn: alu passthrough rd=%0d res=%h", rdW, ALUresW);

        // Back-to-back loads with no idle cycle
        drive(1, 0, 2'b01, 32'h300, 32'h0, 5'd9, 32'h110, 1'b1, 32'h11111111);
        step();
        drive(1, 0, 2'b01, 32'h304, 32'h0, 5'd10, 32'h114, 1'b1, 32'h22222222);
        step();
        $display("txn: back-to-back loads rd=%0d data=%h", rdW, readdataW);

        // Reset in the middle of WAIT
        drive(1, 0, 2'b01, 32'h400, 32'h0, 5'd12, 32'h118, 1'b0, 32'h0);
        step();
        #2;
        chk("midwait_req_before", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midwait_req", {31'd0, dmem_req}, 32'd0);
        chk("midwait_stall", {31'd0, stallM}, 32'd0);
        chk_w_zero("midwait");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h55555555);
        step();
        drive(1, 0, 2'b01, 32'h500, 32'h0, 5'd3, 32'h11C, 1'b1, 32'h0BADF00D);
        step();
        $display("txn: reset mid-WAIT, late ack ignored, next load data=%h", readdataW);

`ifdef MEM_ALIGN_CHECK_EN
        drive(1, 0, 2'b01, 32'h102, 32'h0, 5'd6, 32'h120, 1'b0, 32'h0);
        step();
        chk("mis_flag", {31'd0, misalignW}, 32'd1);
        drive(1, 0, 2'b01, 32'h104, 32'h0, 5'd6, 32'h124, 1'b1, 32'h77777777);
        step();
        chk("mis_clear", {31'd0, misalignW}, 32'd0);
        $display("txn: misaligned load trapped, aligned load clears flag");
`endif

        // Randomized traffic; inputs held while stalled, as the upstream stall would
        held = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!held) begin
                logic [1:0] wb;
                logic mrw;
                mrw = ($urandom_range(0, 3) == 0);
                wb  = 2'($urandom_range(0, 3));
                drive(1'($urandom_range(0, 1)), mrw, wb,
                      ($urandom_range(0, 3) == 0) ? $urandom : {$urandom} & 32'hFFFF_FFFC,
                      $urandom, 5'($urandom_range(0, 31)), $urandom,
                      1'b0, 32'h0);
            end
            dmem_ack   = ($urandom_range(0, 2) != 0);
            dmem_rdata = $urandom;
            step();
            held = e_stall;
            $display("txn %0d: rw=%0d mrw=%0d wb=%0d addr=%h ack=%0d stall=%0d", i,
                     regwriteM, memrwM, wbselM, ALUresM, dmem_ack, e_stall);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32 pipeline. Consumes the EX/MEM pipeline outputs and drives a single-port data-memory bus using a req/ack handshake.
- Asserts a pipeline stall while an access is outstanding.
- Holds the MEM/WB pipeline register that feeds the writeback mux and the resultW forwarding path.

Parameters:
XLEN, 32, datapath and address width
REG_AW, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  reset
regwriteM  in  1  instruction writes rd
memrwM  in  1  store (1 = write memory)
wbselM  in  2  writeback select: 00 ALU, 01 memory read data, 10 pc+4, 11 reserved (treated as 00)
ALUresM  in  XLEN  ALU result; memory address for loads and stores
data_writeM  in  XLEN  store data
rdM  in  REG_AW  destination register
pc4M  in  XLEN  pc+4
dmem_req  out  1  access request
dmem_we  out  1  write enable
dmem_addr  out  XLEN  word address (ALUresM)
dmem_wdata  out  XLEN  store data
dmem_ack  in  1  access complete this cycle
dmem_rdata  in  XLEN  load data, valid when dmem_ack=1 and dmem_we=0
stallM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; hold MEM inputs stable
regwriteW  out  1  MEM/WB regwrite
wbselW  out  2  MEM/WB wbsel
ALUresW  out  XLEN  MEM/WB ALU result
readdataW  out  XLEN  MEM/WB load data
pc4W  out  XLEN  MEM/WB pc+4
rdW  out  REG_AW  MEM/WB rd

Behaviour:
- Reset:
  - One clock. Reset is asynchronous and active-low: clk, rst_n.
  - While rst_n=0: state=IDLE; all MEM/WB outputs are 0; dmem_req=0; stallM=0.
- Access decode:
  - access = memrwM | (wbselM==01).
  - Bubbles (regwrite=0, memrw=0, wbsel=00) cause no access.
- Bus outputs are combinational from the M inputs:
  - dmem_addr = ALUresM, dmem_wdata = data_writeM, dmem_we = memrwM.
  - dmem_req = access in IDLE or WAIT; 0 otherwise and during reset.
- FSM IDLE:
  - access & dmem_ack: completes in the same cycle with zero wait. stallM=0. MEM/WB captures at the edge. Stay in IDLE.
  - access & !dmem_ack: stallM=1. Go to WAIT.
  - No access: MEM/WB captures M inputs. readdataW takes dmem_rdata (don't-care value).
- FSM WAIT:
  - dmem_req stays high. Inputs are held stable by the upstream stall.
  - dmem_ack=0: stallM=1. MEM/WB loads a bubble (regwriteW=0, wbselW=00, rdW=0). Other W fields hold.
  - dmem_ack=1: stallM=0 that cycle. MEM/WB captures the instruction with readdataW=dmem_rdata. Go to IDLE.
- stallM = access & !dmem_ack, in both states.
- Latency: one cycle M→W when dmem_ack is same-cycle. Each wait cycle adds one bubble to W.
- Stores: regwriteW follows regwriteM (normally 0); readdataW is don't-care.
- dmem_ack with no dmem_req: ignored.
- Reset mid-WAIT: dmem_req drops asynchronously. The FSM returns to IDLE and the transaction is abandoned. The memory must tolerate an abandoned request.
- No back-to-back hazard: a new access can begin in the cycle after an ack, with no idle cycle required.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalignW (1 bit, reset 0).
  - An access with ALUresM[1:0]!=0 issues no dmem_req and no stall.
  - MEM/WB captures with regwriteW forced to 0 and misalignW=1 for that instruction. misalignW is 0 otherwise.
- Undefined:
  - No misalignW port. Address bits [1:0] pass through to dmem_addr unchecked.

Decomposition:
- Shared package riscv_pkg:
  - WB_ALU/WB_MEM/WB_PC4 wbsel encodings.
  - MEM FSM state encoding (IDLE, WAIT).
  - XLEN default.
- Sub-module mem_wb_reg: the MEM/WB register with load/bubble controls. The FSM and bus logic stay in mem_stage.

Test Plan:
- Reset: rst_n=0 during a load → dmem_req=0, stallM=0, all W outputs 0. Release → IDLE, no spurious request.
- Zero-wait load: wbselM=01, ALUresM=0x100, rdM=5, regwriteM=1, dmem_ack=1 with rdata=0xDEADBEEF in the same cycle → stallM=0; next edge readdataW=0xDEADBEEF, rdW=5, regwriteW=1, wbselW=01.
- Store with two wait cycles: memrwM=1, addr 0x200, data 0x12345678, ack in the 3rd cycle → dmem_req=1 and dmem_we=1 for 3 cycles; stallM=1,1,0; W shows 2 bubbles (regwriteW=0) then the store.
- ALU passthrough: wbselM=00, ALUresM=0x2A, rdM=7 → dmem_req=0, stallM=0; next edge ALUresW=0x2A, rdW=7.
- Reset mid-WAIT: load stalled for 1 cycle, then rst_n=0 → dmem_req=0 immediately; after release state is IDLE and a late dmem_ack is ignored.
- MEM_ALIGN_CHECK_EN: load at 0x102 → dmem_req=0, stallM=0; next edge misalignW=1, regwriteW=0. Next aligned load → misalignW=0.
